// File: rtl/core_pkg.sv
// core_pkg: shared RV32I pipeline types used around the execute stage
package core;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;

    // alt carries funct7[5] (SUB/SRA/SRAI select)
    typedef struct packed {
        logic [6:0]  opcode;
        logic [2:0]  funct3;
        logic        alt;
        logic [4:0]  rd;
        logic [31:0] imm;
    } de_inst_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
        de_inst_t    de_inst;
        logic [31:0] rs1_value;
        logic [31:0] rs2_value;
        logic        valid;
    } id_ex_t;

    typedef struct packed {
        logic [31:0] rs1_value;
        logic [31:0] rs2_value;
    } reg_fwd_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
        de_inst_t    de_inst;
        logic [31:0] rs1_value;
        logic [31:0] rs2_value;
        logic [31:0] ex_result;
        logic [31:0] ex_addr;
        logic        taken;
        logic        valid;
    } ex_mem_t;

    localparam ex_mem_t ex_mem_rst = '0;
endpackage

// File: rtl/ex_stage_if.sv
// ex_stage_if: decode-side inputs and memory-side outputs of the execute stage
interface ex_stage_if;
    import core::*;
    logic        en;
    logic        flush;
    logic        next_rdy;
    id_ex_t      id_ex;
    reg_fwd_t    reg_fwd;
    ex_mem_t     ex_mem;
    logic        rdy;
    logic        redir_en;
    logic [31:0] redir_pc;
    modport master (output en, flush, next_rdy, id_ex, reg_fwd, input ex_mem, rdy, redir_en, redir_pc);
    modport slave (input en, flush, next_rdy, id_ex, reg_fwd, output ex_mem, rdy, redir_en, redir_pc);
endinterface

// File: rtl/ex_stage.sv
// ex_stage: RV32I execute stage with ALU, branch resolution and optional iterative shifter
module ex_stage #(
    parameter int SHIFT_STEP = 0
) (
    input logic       clk,
    input logic       rst_n,
    ex_stage_if.slave bus
);
    import core::*;
    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
    localparam logic [4:0] STEP = 5'(SHIFT_STEP);

    state_t      state, state_nx;
    de_inst_t    d;
    ex_mem_t     em;
    logic [31:0] pc, a, b, imm, alu, result, addr, shifted, acc, src, stepped, redir_pc;
    logic [4:0]  shamt, cnt, scnt, k, cnt_nx;
    logic [2:0]  f3;
    logic        is_shift, start, step_en, op_done, load, taken, cond, left, arith, sh_left, sh_arith, redir_en;

    assign d        = bus.id_ex.de_inst;
    assign pc       = bus.id_ex.pc;
    assign f3       = d.funct3;
    assign imm      = d.imm;
    assign a        = bus.reg_fwd.rs1_value;
    assign b        = (d.opcode inside {OPC_OPIMM, OPC_LOAD, OPC_STORE, OPC_JALR}) ? imm : bus.reg_fwd.rs2_value;
    assign shamt    = b[4:0];
    assign is_shift = (d.opcode == OPC_OP || d.opcode == OPC_OPIMM) && f3[1:0] == 2'b01;
    assign start    = bus.id_ex.valid && is_shift && shamt != 5'd0;
    assign op_done  = SHIFT_STEP == 0 || state == DONE || (state == IDLE && !start);
    assign step_en  = SHIFT_STEP != 0 && bus.en && !bus.flush && (state == SHIFT || (state == IDLE && start));

    // First step is taken on the IDLE cycle, so the stall is ceil(shamt/SHIFT_STEP) cycles
    assign src     = state == IDLE ? a : acc;
    assign scnt    = state == IDLE ? shamt : cnt;
    assign left    = state == IDLE ? !f3[2] : sh_left;
    assign arith   = state == IDLE ? d.alt : sh_arith;
    assign k       = scnt > STEP ? STEP : scnt;
    assign cnt_nx  = scnt - k;
    assign stepped = left ? src << k : arith ? 32'($signed(src) >>> k) : src >> k;
    assign shifted = (SHIFT_STEP != 0 && state == DONE) ? acc :
                     !f3[2] ? a << shamt : d.alt ? 32'($signed(a) >>> shamt) : a >> shamt;

    always_comb begin
        case (f3)
            3'b000:  alu = (d.opcode == OPC_OP && d.alt) ? a - b : a + b;
            3'b010:  alu = {31'b0, $signed(a) < $signed(b)};
            3'b011:  alu = {31'b0, a < b};
            3'b100:  alu = a ^ b;
            3'b110:  alu = a | b;
            3'b111:  alu = a & b;
            default: alu = shifted;
        endcase
    end

    always_comb begin
        case (f3)
            3'b000:  cond = a == b;
            3'b001:  cond = a != b;
            3'b100:  cond = $signed(a) < $signed(b);
            3'b101:  cond = $signed(a) >= $signed(b);
            3'b110:  cond = a < b;
            3'b111:  cond = a >= b;
            default: cond = 1'b0;
        endcase
    end

    always_comb begin
        result = 32'b0;
        addr   = 32'b0;
        taken  = 1'b0;
        case (d.opcode)
            OPC_OP, OPC_OPIMM: result = alu;
            OPC_LOAD:          result = a + imm;
            OPC_LUI:           result = imm;
            OPC_AUIPC:         result = pc + imm;
            OPC_JAL: begin
                result = pc + 32'd4;
                addr   = pc + imm;
                taken  = 1'b1;
            end
            OPC_JALR: begin
                result = pc + 32'd4;
                addr   = (a + imm) & ~32'd1;
                taken  = 1'b1;
            end
            OPC_BRANCH: begin
                addr  = pc + imm;
                taken = cond;
            end
            default: ;
        endcase
    end

    always_comb begin
        state_nx = state;
        if (bus.flush) state_nx = IDLE;
        else if (step_en) state_nx = cnt_nx == 5'd0 ? DONE : SHIFT;
        else if (bus.en && bus.next_rdy && state == DONE) state_nx = IDLE;
    end

    assign load     = bus.en && bus.id_ex.valid && op_done && !bus.flush;
    assign bus.rdy  = bus.en && bus.next_rdy && op_done;
    assign bus.ex_mem   = em;
    assign bus.redir_en = redir_en;
    assign bus.redir_pc = redir_pc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            acc      <= '0;
            cnt      <= '0;
            sh_left  <= 1'b0;
            sh_arith <= 1'b0;
            em       <= ex_mem_rst;
            redir_en <= 1'b0;
            redir_pc <= '0;
        end else begin
            state <= state_nx;
            if (state == IDLE) begin
                sh_left  <= left;
                sh_arith <= arith;
            end
            if (step_en) begin
                acc <= stepped;
                cnt <= cnt_nx;
            end
            redir_en <= bus.next_rdy && load && taken;
            if (bus.next_rdy && load && taken) redir_pc <= addr;
            if (bus.next_rdy) em <= '{pc: pc, inst: bus.id_ex.inst, de_inst: d, rs1_value: bus.id_ex.rs1_value,
                                      rs2_value: bus.id_ex.rs2_value, ex_result: result, ex_addr: addr,
                                      taken: taken, valid: load};
            else if (bus.flush) em.valid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_ex_stage.sv
// tb_ex_stage: scoreboard bench for ex_stage with an iterative 4-bit-per-cycle shifter
module tb_ex_stage;
    import core::*;

    typedef struct {
        logic [31:0] pc, inst, rs2, res, addr;
        logic        taken;
        int          lat;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    logic nr_q = 1'b0;
    int   nchk = 0;
    int   nerr = 0;
    exp_t q[$];
    exp_t last, cur;

    ex_stage_if bus ();
    ex_stage #(.SHIFT_STEP(4)) dut (.clk(clk), .rst_n(rst_n), .bus(bus.slave));

    always #5 clk = ~clk;

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] req);
        nchk++;
        if (act !== req) begin
            nerr++;
            $display("FAIL %s: got %h, expected %h", n, act, req);
        end
    endtask

    function automatic exp_t model(input id_ex_t x, input reg_fwd_t f);
        exp_t        e;
        logic [6:0]  op  = x.de_inst.opcode;
        logic [2:0]  f3  = x.de_inst.funct3;
        logic        alt = x.de_inst.alt;
        logic [31:0] a   = f.rs1_value;
        logic [31:0] imm = x.de_inst.imm;
        logic [31:0] b;
        int          sh;
        e.pc = x.pc; e.inst = x.inst; e.rs2 = x.rs2_value;
        e.res = 0; e.addr = 0; e.taken = 0; e.lat = 0;
        b  = (op == OPC_OPIMM || op == OPC_LOAD || op == OPC_STORE || op == OPC_JALR) ? imm : f.rs2_value;
        sh = int'(b[4:0]);
        case (op)
            OPC_OP, OPC_OPIMM: begin
                case (f3)
                    3'd0: e.res = (op == OPC_OP && alt) ? a - b : a + b;
                    3'd1: e.res = a << sh;
                    3'd2: e.res = ($signed(a) < $signed(b)) ? 1 : 0;
                    3'd3: e.res = (a < b) ? 1 : 0;
                    3'd4: e.res = a ^ b;
                    3'd5: e.res = alt ? 32'($signed(a) >>> sh) : a >> sh;
                    3'd6: e.res = a | b;
                    3'd7: e.res = a & b;
                endcase
                if (f3 == 3'd1 || f3 == 3'd5) e.lat = (sh + 3) / 4;
            end
            OPC_LOAD:  e.res = a + imm;
            OPC_LUI:   e.res = imm;
            OPC_AUIPC: e.res = x.pc + imm;
            OPC_JAL: begin
                e.res = x.pc + 4; e.addr = x.pc + imm; e.taken = 1;
            end
            OPC_JALR: begin
                e.res = x.pc + 4; e.addr = a + imm; e.addr[0] = 1'b0; e.taken = 1;
            end
            OPC_BRANCH: begin
                e.addr = x.pc + imm;
                case (f3)
                    3'd0: e.taken = a == b;
                    3'd1: e.taken = a != b;
                    3'd4: e.taken = $signed(a) < $signed(b);
                    3'd5: e.taken = $signed(a) >= $signed(b);
                    3'd6: e.taken = a < b;
                    3'd7: e.taken = a >= b;
                    default: e.taken = 0;
                endcase
            end
            default: ;
        endcase
        return e;
    endfunction

    always @(posedge clk) nr_q <= bus.next_rdy;

    // An output is new only when the previous edge had next_rdy high; otherwise it must hold
    always @(negedge clk) begin
        if (rst_n) begin
            if (nr_q && bus.ex_mem.valid) begin
                if (q.size() == 0) chk("spurious_valid", 32'd1, 32'd0);
                else begin
                    cur = q.pop_front();
                    chk("pc", bus.ex_mem.pc, cur.pc);
                    chk("inst", bus.ex_mem.inst, cur.inst);
                    chk("rs2_copy", bus.ex_mem.rs2_value, cur.rs2);
                    chk("ex_result", bus.ex_mem.ex_result, cur.res);
                    chk("ex_addr", bus.ex_mem.ex_addr, cur.addr);
                    chk("redir_en", {31'b0, bus.redir_en}, {31'b0, cur.taken});
                    if (cur.taken) chk("redir_pc", bus.redir_pc, cur.addr);
                    last = cur;
                end
            end else begin
                chk("redir_idle", {31'b0, bus.redir_en}, 32'd0);
                if (!nr_q && bus.ex_mem.valid) begin
                    chk("hold_result", bus.ex_mem.ex_result, last.res);
                    chk("hold_pc", bus.ex_mem.pc, last.pc);
                end
            end
        end
    end

    task automatic send(input id_ex_t x, input reg_fwd_t f, input int stall, input bit rnd);
        exp_t e = model(x, f);
        int   lo = 0;
        bit   clean = 1;
        bit   done = 0;
        bit   scram = !rnd && e.lat != 0;
        for (int c = 0; c < 200 && !done; c++) begin
            @(negedge clk);
            bus.id_ex    = x;
            bus.reg_fwd  = (scram && c > 0) ? reg_fwd_t'({$urandom(), $urandom()}) : f;
            bus.next_rdy = (c < stall) ? 1'b0 : rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
            bus.en       = rnd ? ($urandom_range(0, 7) != 0) : 1'b1;
            bus.flush    = rnd && $urandom_range(0, 15) == 0;
            if (!(bus.next_rdy && bus.en) || bus.flush) clean = 0;
            #1;
            if (!bus.next_rdy || !bus.en) chk("rdy_gate", {31'b0, bus.rdy}, 32'd0);
            if (bus.rdy) begin
                done = 1;
                if (!bus.flush) q.push_back(e);
                if (clean) chk("latency", lo, e.lat);
            end else lo++;
        end
        chk("send_timeout", {31'b0, done}, 32'd1);
        @(negedge clk);
        bus.flush = 1'b0;
        bus.id_ex.valid = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            bus.id_ex.valid = 1'b0;
            bus.flush = 1'b0;
            bus.next_rdy = 1'b1;
            bus.en = 1'($urandom_range(0, 1));
        end
    endtask

    function automatic id_ex_t mk(input logic [6:0] op, input logic [2:0] f3, input logic alt,
                                  input logic [31:0] imm, input logic [31:0] pc);
        id_ex_t x = '0;
        x.valid = 1; x.pc = pc; x.inst = $urandom();
        x.rs1_value = $urandom(); x.rs2_value = $urandom();
        x.de_inst.opcode = op; x.de_inst.funct3 = f3; x.de_inst.alt = alt; x.de_inst.imm = imm;
        x.de_inst.rd = 5'($urandom_range(0, 31));
        return x;
    endfunction

    function automatic reg_fwd_t fw(input logic [31:0] a, input logic [31:0] b);
        reg_fwd_t f;
        f.rs1_value = a; f.rs2_value = b;
        return f;
    endfunction

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 5))
            0: return 32'h0;
            1: return 32'h1;
            2: return 32'h7FFF_FFFF;
            3: return 32'h8000_0000;
            4: return 32'hFFFF_FFFF;
            default: return $urandom();
        endcase
    endfunction

    task automatic rand_send(input bit rnd);
        logic [6:0] ops [9] = '{OPC_LOAD, OPC_OPIMM, OPC_AUIPC, OPC_STORE, OPC_OP, OPC_LUI, OPC_BRANCH, OPC_JALR, OPC_JAL};
        id_ex_t   x;
        reg_fwd_t f;
        int       v = $urandom_range(0, 4095) - 2048;
        x = mk(ops[$urandom_range(0, 8)], 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), 32'(v),
               $urandom() & 32'hFFFF_FFFC);
        if (x.de_inst.opcode == OPC_LUI || x.de_inst.opcode == OPC_AUIPC) x.de_inst.imm = $urandom() & 32'hFFFF_F000;
        f.rs1_value = pick();
        f.rs2_value = $urandom_range(0, 1) ? f.rs1_value : pick();
        send(x, f, 0, rnd);
    endtask

    initial begin
        bus.en = 0; bus.flush = 0; bus.next_rdy = 0; bus.id_ex = '0; bus.reg_fwd = '0;
        #1 rst_n = 1'b0;
        #2;
        chk("rst_valid", {31'b0, bus.ex_mem.valid}, 32'd0);
        chk("rst_redir_en", {31'b0, bus.redir_en}, 32'd0);
        chk("rst_redir_pc", bus.redir_pc, 32'd0);
        chk("rst_rdy", {31'b0, bus.rdy}, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        send(mk(OPC_OP, 3'd0, 1'b0, 32'h0, 32'h10), fw(32'h7FFF_FFFF, 32'h1), 0, 0);
        send(mk(OPC_OP, 3'd0, 1'b1, 32'h0, 32'h14), fw(32'h0, 32'h1), 0, 0);
        send(mk(OPC_OPIMM, 3'd5, 1'b1, 32'h40D, 32'h18), fw(32'h8000_0000, 32'h0), 0, 0);
        send(mk(OPC_BRANCH, 3'd0, 1'b0, 32'hFFFF_FFF8, 32'h100), fw(32'h5, 32'h5), 0, 0);
        send(mk(OPC_BRANCH, 3'd1, 1'b0, 32'hFFFF_FFF8, 32'h100), fw(32'h5, 32'h5), 0, 0);
        send(mk(OPC_JALR, 3'd0, 1'b0, 32'h2, 32'h40), fw(32'h1001, 32'h0), 0, 0);
        send(mk(OPC_OP, 3'd0, 1'b0, 32'h0, 32'h44), fw(32'h1234, 32'h4321), 3, 0);
        send(mk(OPC_BRANCH, 3'd0, 1'b0, 32'hFFFF_FFF8, 32'h100), fw(32'h9, 32'h9), 3, 0);
        send(mk(OPC_OPIMM, 3'd1, 1'b0, 32'h0, 32'h50), fw(32'hDEAD_BEEF, 32'h0), 0, 0);
        // flush while ex_mem holds a valid result must kill it
        send(mk(OPC_OP, 3'd4, 1'b0, 32'h0, 32'h54), fw(32'hF0F0_F0F0, 32'h0FF0_0FF0), 0, 0);
        bus.next_rdy = 1'b0; bus.flush = 1'b1;
        @(negedge clk);
        bus.flush = 1'b0;
        chk("flush_kill", {31'b0, bus.ex_mem.valid}, 32'd0);
        // abort a shift with flush, then with reset, each followed by a normal shift
        @(negedge clk);
        bus.id_ex = mk(OPC_OPIMM, 3'd5, 1'b0, 32'hD, 32'h60); bus.reg_fwd = fw(32'h8000_0000, 0);
        bus.en = 1; bus.next_rdy = 1;
        repeat (2) @(negedge clk);
        bus.flush = 1'b1;
        @(negedge clk);
        bus.flush = 1'b0; bus.id_ex.valid = 1'b0;
        send(mk(OPC_OPIMM, 3'd5, 1'b1, 32'h40D, 32'h64), fw(32'h8000_0000, 32'h0), 0, 0);
        @(negedge clk);
        bus.id_ex = mk(OPC_OP, 3'd1, 1'b0, 32'h0, 32'h70); bus.reg_fwd = fw(32'h1, 32'd13);
        bus.en = 1; bus.next_rdy = 1;
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("midrst_valid", {31'b0, bus.ex_mem.valid}, 32'd0);
        chk("midrst_redir_en", {31'b0, bus.redir_en}, 32'd0);
        chk("midrst_redir_pc", bus.redir_pc, 32'd0);
        @(negedge clk);
        rst_n = 1'b1; bus.id_ex.valid = 1'b0;
        send(mk(OPC_OP, 3'd1, 1'b0, 32'h0, 32'h74), fw(32'h1, 32'd13), 0, 0);
        for (int i = 0; i < 300; i++) begin
            rand_send(i % 4 != 0);
            if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
        end
        idle(4);
        chk("queue_empty", q.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", nchk, nerr);
        $finish;
    end
endmodule
